rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised round-robin bus arbiter, the next generation of the fixed four-client arbiter. It handles NUM_CLIENTS requesters through a request vector and keeps one registered grant open until the server acknowledges it or the client withdraws. It then rotates priority so the client after the last served one is considered first. It sits between the client request lines and the single shared server port of the bus arbiter.

## Interface
- NUM_CLIENTS, 4: number of requesters, 2..32.
- WEIGHT_W, 4: width of each per-client weight field. Used only when ARB_WEIGHT_EN is defined.
- IDX_W (localparam), $clog2(NUM_CLIENTS): width of the client index.
- Reset is reset, asynchronous, active-high. The clock is clk.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  allows new grants to be issued.
- client_rq  in  NUM_CLIENTS  request vector, bit i = client i.
- server_ack  in  1  server completed the current transfer.
- weights  in  NUM_CLIENTS*WEIGHT_W  client i weight at [i*WEIGHT_W +: WEIGHT_W]. Ignored without ARB_WEIGHT_EN.
- grant_valid  out  1  a grant is open.
- grant_idx  out  IDX_W  index of the granted client.
- grant_onehot  out  NUM_CLIENTS  one-hot form of grant_idx while grant_valid is high. Otherwise all zero.

## Operation
- State: FSM {IDLE, GRANT}; rotation pointer ptr[IDX_W-1:0]; burst credit counter credit[WEIGHT_W-1:0].
- Reset values: state=IDLE, ptr=0, credit=1, grant_valid=0, grant_idx=0, grant_onehot=0.
- IDLE, enable=1 and |client_rq:
  - Select the first set bit scanning ptr, ptr+1, …, NUM_CLIENTS-1, 0, …, ptr-1, wrapping modulo NUM_CLIENTS.
  - Register that client into grant_idx and grant_onehot, set grant_valid=1, go to GRANT.
- IDLE, enable=0 or no request: stay in IDLE with outputs unchanged (grant_valid=0).
- GRANT, server_ack=1: close the grant (grant_valid=0), go to IDLE, then update ptr:
  - Without ARB_WEIGHT_EN: ptr <= (grant_idx+1) mod NUM_CLIENTS. Index NUM_CLIENTS-1 wraps to 0.
  - With ARB_WEIGHT_EN: see Configuration.
- GRANT, client_rq[grant_idx]=0 and server_ack=0 (withdrawal):
  - Cancel the grant (grant_valid=0), go to IDLE.
  - ptr <= (grant_idx+1) mod NUM_CLIENTS; credit reloads.
- GRANT, server_ack=1 and withdrawal in the same cycle: treated as ack.
- GRANT, neither ack nor withdrawal: hold grant_idx and grant_onehot stable.
- enable has no effect on an open grant. Dropping enable never cancels a grant.
- server_ack in IDLE is ignored.
- Non-requesting clients never receive a grant.
- At most one grant is open at any time.

## Timing
- Grant latency: request sampled at edge k in IDLE gives grant_valid=1 after edge k.
- Release: ack sampled at edge m gives grant_valid=0 after edge m.
- The cycle after a release is always IDLE. Minimum grant-to-grant spacing is 2 cycles, and the next arbitration uses the updated ptr.
- All outputs are registered. No combinational path exists from any input to any output.
- Reset asserted mid-grant: all outputs clear asynchronously. After release, the first grant goes to the lowest-index requester (ptr=0).

## Configuration
- Macro: ARB_WEIGHT_EN.
- Defined: weighted round-robin.
  - credit reloads to max(weights[i],1) whenever ptr moves to client i. Weight 0 is treated as 1. On reset credit=1.
  - On ack, if credit>1, ptr stays and credit decrements. The same client wins the next arbitration if it still requests; otherwise the scan continues from ptr.
  - On ack with credit<=1, ptr advances and credit reloads from the new client's weight.
  - Withdrawal always advances ptr and reloads credit.
- Undefined: the weights port is unused, credit logic is removed, and behaviour is pure round-robin as in Operation.

## Test plan
- Reset then client_rq=4'b1111, ack on each grant → grant_idx sequence 0,1,2,3,0; grant_valid high 1 cycle after each IDLE.
- ptr=3 (after serving client 2), client_rq=4'b0101 → grant 0 (wrap), then 2.
- Grant open to client 1, enable dropped, ack 5 cycles later → grant_idx=1 held for 5 cycles, then grant_valid=0, no new grant while enable=0.
- Grant to client 2, client_rq[2] deasserted without ack → grant_valid=0 next cycle; with client_rq=4'b1001 the next grant is 3.
- Reset asserted while grant_valid=1 → all outputs 0 immediately; after release with client_rq=4'b1010, grant_idx=1.
- ARB_WEIGHT_EN, weights={1,1,3,1} (client 3..0), client_rq=4'b0110 constant with acks → grants 1,2,2,2,1,2,2,2.

Source files
------------

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter for NUM_CLIENTS requesters with one registered grant open at a time.
// Define ARB_WEIGHT_EN to enable weighted round-robin using the per-client weights port.
module rr_arbiter_n #(
  parameter int NUM_CLIENTS = 4,
  parameter int WEIGHT_W    = 4,
  localparam int IDX_W      = $clog2(NUM_CLIENTS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_CLIENTS-1:0]        client_rq,
  input  logic                          server_ack,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] weights,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic [NUM_CLIENTS-1:0]        grant_onehot
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_CLIENTS - 1);
  localparam logic [NUM_CLIENTS-1:0] ONE_HOT0 = NUM_CLIENTS'(1);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [NUM_CLIENTS-1:0] onehot_q, onehot_d;
  logic                   found_c;
  logic [IDX_W-1:0]       pick_c;
  logic [IDX_W-1:0]       next_ptr_c;

`ifdef ARB_WEIGHT_EN
  logic [WEIGHT_W-1:0]    credit_q, credit_d;

  // A weight of zero still earns the client one grant per visit.
  function automatic logic [WEIGHT_W-1:0] reload_credit(
    input logic [IDX_W-1:0]                who,
    input logic [NUM_CLIENTS*WEIGHT_W-1:0] w
  );
    logic [WEIGHT_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (IDX_W'(i) == who) v = w[i*WEIGHT_W +: WEIGHT_W];
    end
    return (v == '0) ? WEIGHT_W'(1) : v;
  endfunction
`else
  logic unused_weights;
  assign unused_weights = ^weights;
`endif

  // Scan requests starting at ptr and wrapping, first set bit wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    found_c = 1'b0;
    pick_c  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % NUM_CLIENTS);
      if (!found_c && client_rq[cand]) begin
        found_c = 1'b1;
        pick_c  = cand;
      end
    end
  end

  assign next_ptr_c = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

  // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    onehot_d    = onehot_q;
`ifdef ARB_WEIGHT_EN
    credit_d    = credit_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable && found_c) begin
          state_d     = GRANT;
          grant_idx_d = pick_c;
          onehot_d    = ONE_HOT0 << pick_c;
        end
      end
      GRANT: begin
        if (server_ack) begin
          state_d  = IDLE;
          onehot_d = '0;
`ifdef ARB_WEIGHT_EN
          if (credit_q > WEIGHT_W'(1)) begin
            credit_d = credit_q - 1'b1;
          end else begin
            ptr_d    = next_ptr_c;
            credit_d = reload_credit(next_ptr_c, weights);
          end
`else
          ptr_d    = next_ptr_c;
`endif
        end else if (!client_rq[grant_idx_q]) begin
          state_d  = IDLE;
          onehot_d = '0;
          ptr_d    = next_ptr_c;
`ifdef ARB_WEIGHT_EN
          credit_d = reload_credit(next_ptr_c, weights);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      onehot_q    <= '0;
`ifdef ARB_WEIGHT_EN
      credit_q    <= WEIGHT_W'(1);
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      onehot_q    <= onehot_d;
`ifdef ARB_WEIGHT_EN
      credit_q    <= credit_d;
`endif
    end
  end

  assign grant_valid  = (state_q == GRANT);
  assign grant_idx    = grant_idx_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// Self-checking bench for rr_arbiter_n: directed scenarios plus random traffic against a
// transaction-level reference model (weighted mode follows ARB_WEIGHT_EN).
module tb_rr_arbiter_n;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           enable = 1'b0;
  logic [N-1:0]   client_rq = '0;
  logic           server_ack = 1'b0;
  logic [N*W-1:0] weights = '0;
  logic           grant_valid;
  logic [1:0]     grant_idx;
  logic [N-1:0]   grant_onehot;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one open grant, a rotation pointer and a burst credit.
  int m_busy, m_idx, m_ptr, m_credit;

  rr_arbiter_n #(.NUM_CLIENTS(N), .WEIGHT_W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .client_rq   (client_rq),
    .server_ack  (server_ack),
    .weights     (weights),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int weight_of(input int c);
    int v;
    v = int'((weights >> (c * W)) & ((1 << W) - 1));
    return (v == 0) ? 1 : v;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_idx = 0; m_ptr = 0; m_credit = 1;
  endtask

  task automatic model_step();
    if (reset) begin
      model_reset();
    end else if (m_busy == 0) begin
      if (enable && client_rq != '0) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (m_ptr + k) % N;
          if (m_busy == 0 && client_rq[c]) begin
            m_busy = 1;
            m_idx  = c;
          end
        end
      end
    end else if (server_ack) begin
      m_busy = 0;
`ifdef ARB_WEIGHT_EN
      if (m_credit > 1) begin
        m_credit = m_credit - 1;
      end else begin
        m_ptr    = (m_idx + 1) % N;
        m_credit = weight_of(m_ptr);
      end
`else
      m_ptr = (m_idx + 1) % N;
`endif
    end else if (!client_rq[m_idx]) begin
      m_busy   = 0;
      m_ptr    = (m_idx + 1) % N;
      m_credit = weight_of(m_ptr);
    end
  endtask

  task automatic compare_model();
    check("valid", 32'(grant_valid), 32'(m_busy));
    check("idx", 32'(grant_idx), 32'(m_idx));
    check("onehot", 32'(grant_onehot), (m_busy != 0) ? (32'd1 << m_idx) : 32'd0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int seq_a[5];
    int seq_w[8];
    seq_a = '{0, 1, 2, 3, 0};
    seq_w = '{1, 2, 2, 2, 1, 2, 2, 2};
    model_reset();

    // Reset state.
    do_reset();
    check("rst_valid", 32'(grant_valid), 32'd0);
    check("rst_idx", 32'(grant_idx), 32'd0);
    check("rst_onehot", 32'(grant_onehot), 32'd0);

    // Full rotation with every client requesting.
    enable = 1'b1; client_rq = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      server_ack = 1'b0; cycle();
      check("rot_valid", 32'(grant_valid), 32'd1);
      check("rot_idx", 32'(grant_idx), 32'(seq_a[j]));
      server_ack = 1'b1; cycle();
      check("rot_release", 32'(grant_valid), 32'd0);
    end

    // Serve client 2 so ptr=3, then a wrap to client 0 followed by client 2.
    server_ack = 1'b0; client_rq = 4'b0100; cycle();
    check("c2_idx", 32'(grant_idx), 32'd2);
    server_ack = 1'b1; cycle();
    server_ack = 1'b0; client_rq = 4'b0101; cycle();
    check("wrap_idx", 32'(grant_idx), 32'd0);
    server_ack = 1'b1; cycle();
    server_ack = 1'b0; cycle();
    check("wrap_next", 32'(grant_idx), 32'd2);
    server_ack = 1'b1; cycle();

    // Dropping enable holds an open grant; no new grant while enable is low.
    server_ack = 1'b0; client_rq = 4'b0010; cycle();
    check("hold_start", 32'(grant_idx), 32'd1);
    enable = 1'b0;
    repeat (5) begin
      cycle();
      check("hold_valid", 32'(grant_valid), 32'd1);
      check("hold_idx", 32'(grant_idx), 32'd1);
    end
    server_ack = 1'b1; cycle();
    check("hold_release", 32'(grant_valid), 32'd0);
    server_ack = 1'b0;
    repeat (3) begin
      cycle();
      check("dis_nogrant", 32'(grant_valid), 32'd0);
    end

    // Withdrawal of client 2 cancels its grant; next scan starts at 3.
    enable = 1'b1; client_rq = 4'b0100; cycle();
    check("wd_grant", 32'(grant_idx), 32'd2);
    client_rq = 4'b1001; cycle();
    check("wd_cancel", 32'(grant_valid), 32'd0);
    cycle();
    check("wd_next", 32'(grant_idx), 32'd3);
    check("wd_valid", 32'(grant_valid), 32'd1);

    // Asynchronous reset in the middle of a grant.
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 32'(grant_valid), 32'd0);
    check("arst_idx", 32'(grant_idx), 32'd0);
    check("arst_onehot", 32'(grant_onehot), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0; client_rq = 4'b1010;
    cycle();
    check("arst_first", 32'(grant_idx), 32'd1);
    server_ack = 1'b1; cycle();
    server_ack = 1'b0;

`ifdef ARB_WEIGHT_EN
    // Weighted rotation: client 2 has weight 3, others 1.
    weights = {4'd1, 4'd1, 4'd3, 4'd1};
    do_reset();
    client_rq = 4'b0110; enable = 1'b1;
    for (int j = 0; j < 8; j++) begin
      server_ack = 1'b0; cycle();
      check("wrr_idx", 32'(grant_idx), 32'(seq_w[j]));
      server_ack = 1'b1; cycle();
    end
    server_ack = 1'b0;
`endif

    // Random traffic against the reference model.
    do_reset();
    for (int j = 0; j < 600; j++) begin
      client_rq  = N'($urandom);
      enable     = ($urandom_range(0, 3) != 0);
      server_ack = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) weights = (N*W)'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
